// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU request scheduler.
//   - ALU opcode constants (add .. nxor, 1..13)
//   - response error codes
//   - scheduler FSM state encoding
//   - opcode legality helper
package alu_ctrl_pkg;

    // ALU opcodes understood by the breadboard ALU.
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_MUL  = 5'd3;
    localparam logic [4:0] OP_DIV  = 5'd4;
    localparam logic [4:0] OP_MOD  = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_AND  = 5'd8;
    localparam logic [4:0] OP_OR   = 5'd9;
    localparam logic [4:0] OP_XOR  = 5'd10;
    localparam logic [4:0] OP_NAND = 5'd11;
    localparam logic [4:0] OP_NOR  = 5'd12;
    localparam logic [4:0] OP_NXOR = 5'd13;

    // Response error codes.
    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_DIV0 = 2'd2;
    localparam logic [1:0] ERR_ILL  = 2'd3;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } sched_state_e;

    // Legal opcodes are 1..op_max; 0 is never legal.
    function automatic logic op_legal(input logic [4:0] cmd, input int unsigned op_max);
        return (cmd != 5'd0) && (32'(cmd) <= op_max);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//   req  - request vector, bit i from requester i
//   last - index of the requester served most recently
//   gnt  - one-hot grant (all zero when no request)
// The pointer register lives in the parent.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // Contention: favour whoever was not served last.
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one breadboard ALU between two requesters.
// Requests are round-robin arbitrated in IDLE; a granted legal opcode is
// issued to the ALU for one cycle, the scheduler waits ALU_LAT cycles, then
// returns the accumulator plus an error code on a valid/ready channel.
// Illegal opcodes skip the ALU and answer immediately with ERR_ILL.
//
// Ports:
//   CLK, RST          clock (rising edge), synchronous active-high reset
//   req*/cmd*/a*/b*   requester 0/1 request, opcode, operands
//   gnt0/gnt1         combinational grant, only in IDLE
//   rsp_*             response channel (valid/ready, id, data, err)
//   busy              state is not IDLE
//   alu_*             ALU operand/command/hold/reset outputs
//   alu_acc, alu_overflow, alu_divByZero   ALU results sampled at capture
module alu_req_scheduler
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned N       = 16,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned OP_MAX  = 13
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           req0,
    input  logic           req1,
    input  logic [4:0]     cmd0,
    input  logic [4:0]     cmd1,
    input  logic [N-1:0]   a0,
    input  logic [N-1:0]   a1,
    input  logic [N-1:0]   b0,
    input  logic [N-1:0]   b1,
    output logic           gnt0,
    output logic           gnt1,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*N-1:0] rsp_data,
    output logic [1:0]     rsp_err,
    output logic           busy,
    output logic [N-1:0]   alu_A,
    output logic [N-1:0]   alu_B,
    output logic [4:0]     alu_cmd,
    output logic           alu_noOp,
    output logic           alu_rst,
    input  logic [2*N-1:0] alu_acc,
    input  logic           alu_overflow,
    input  logic           alu_divByZero
);

    localparam int unsigned CntW = 3;

    sched_state_e   state_q, state_d;
    logic           last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic           rsp_id_q, rsp_id_d;
    logic [2*N-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]     rsp_err_q, rsp_err_d;
    logic [N-1:0]   alu_a_q, alu_a_d;
    logic [N-1:0]   alu_b_q, alu_b_d;
    logic [4:0]     alu_cmd_q, alu_cmd_d;

    logic [1:0]     arb_gnt;
    logic [1:0]     gnt_vec;
    logic           sel;
    logic [4:0]     sel_cmd;
    logic [N-1:0]   sel_a;
    logic [N-1:0]   sel_b;

    rr_arb2 u_arb (
        .req  ({req1, req0}),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    // Grants are suppressed during reset so nothing transfers on a reset edge.
    assign gnt_vec = (state_q == StIdle && !RST) ? arb_gnt : 2'b00;
    assign gnt0    = gnt_vec[0];
    assign gnt1    = gnt_vec[1];

    assign sel     = gnt_vec[1];
    assign sel_cmd = sel ? cmd1 : cmd0;
    assign sel_a   = sel ? a1 : a0;
    assign sel_b   = sel ? b1 : b0;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_cmd_d  = alu_cmd_q;

        unique case (state_q)
            StIdle: begin
                if (gnt_vec != 2'b00) begin
                    last_d   = sel;
                    rsp_id_d = sel;
                    if (op_legal(sel_cmd, OP_MAX)) begin
                        // Operands are loaded here so they are on the ALU
                        // pins during the ISSUE cycle.
                        alu_a_d   = sel_a;
                        alu_b_d   = sel_b;
                        alu_cmd_d = sel_cmd;
                        state_d   = StIssue;
                    end else begin
                        // ALU is left untouched for an illegal opcode.
                        rsp_err_d  = ERR_ILL;
                        rsp_data_d = '0;
                        state_d    = StResp;
                    end
                end
            end
            StIssue: begin
                cnt_d   = CntW'(ALU_LAT - 1);
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    rsp_data_d = alu_acc;
                    // Flags only mean something for the opcode that raises them.
                    if (alu_cmd_q == OP_DIV && alu_divByZero) begin
                        rsp_err_d = ERR_DIV0;
                    end else if (alu_cmd_q == OP_ADD && alu_overflow) begin
                        rsp_err_d = ERR_OVF;
                    end else begin
                        rsp_err_d = ERR_OK;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            last_q     <= 1'b1; // port 1 "served last" so port 0 wins first
            cnt_q      <= '0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= ERR_OK;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_cmd_q  <= 5'd0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_cmd_q  <= alu_cmd_d;
        end
    end

    assign rsp_valid = (state_q == StResp);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != StIdle);

    assign alu_A     = alu_a_q;
    assign alu_B     = alu_b_q;
    assign alu_cmd   = alu_cmd_q;
    // ALU only runs in the ISSUE cycle, and never while reset is applied.
    assign alu_noOp  = RST || (state_q != StIssue);
    assign alu_rst   = RST;

endmodule

// File: tb/tb_alu_req_scheduler.sv
module tb_alu_req_scheduler;
    import alu_ctrl_pkg::*;

    localparam int unsigned N   = 16;
    localparam int unsigned LAT = 1;
    localparam int unsigned OPM = 13;
    localparam int unsigned W   = 2 * N;

    logic           clk = 1'b0;
    logic           RST;
    logic           req0, req1;
    logic [4:0]     cmd0, cmd1;
    logic [N-1:0]   a0, a1, b0, b1;
    logic           gnt0, gnt1;
    logic           rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0]   rsp_data;
    logic [1:0]     rsp_err;
    logic           busy;
    logic [N-1:0]   alu_A, alu_B;
    logic [4:0]     alu_cmd;
    logic           alu_noOp, alu_rst;
    logic [W-1:0]   alu_acc;
    logic           alu_overflow, alu_divByZero;

    always #5 clk = ~clk;

    alu_req_scheduler #(.N(N), .ALU_LAT(LAT), .OP_MAX(OPM)) dut (
        .CLK(clk), .RST(RST),
        .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .alu_A(alu_A), .alu_B(alu_B), .alu_cmd(alu_cmd),
        .alu_noOp(alu_noOp), .alu_rst(alu_rst),
        .alu_acc(alu_acc), .alu_overflow(alu_overflow), .alu_divByZero(alu_divByZero)
    );

    // Simple ALU: computes one result per non-held cycle (latency 1).
    function automatic logic [W-1:0] alu_fn(input logic [4:0] c, input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        case (c)
            5'd1:    return W'(a) + W'(b);
            5'd2:    return W'(a) - W'(b);
            5'd3:    return W'(a) * W'(b);
            5'd4:    return (b == '0) ? '0 : W'(a / b);
            default: return W'(a ^ b);
        endcase
    endfunction

    logic [W-1:0] acc_m;
    logic         dbz_m;
    logic         ovf_drv, dbz_drv;

    always @(posedge clk) begin
        if (alu_rst) begin
            acc_m <= '0;
            dbz_m <= 1'b0;
        end else if (!alu_noOp) begin
            acc_m <= alu_fn(alu_cmd, alu_A, alu_B);
            dbz_m <= (alu_cmd == 5'd4) && (alu_B == '0);
        end
    end

    assign alu_acc       = acc_m;
    assign alu_overflow  = ovf_drv;
    assign alu_divByZero = dbz_m | dbz_drv;

    int checks = 0;
    int errors = 0;
    int last_srv = 1; // reference round-robin memory: who was served last

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic legal(input logic [4:0] c);
        return (c >= 5'd1) && (int'(c) <= int'(OPM));
    endfunction

    function automatic logic [1:0] exp_err(input logic [4:0] c, input logic [N-1:0] b,
                                           input logic ovf, input logic dbzf);
        if (!legal(c)) return 2'd3;
        if (c == 5'd4 && (b == '0 || dbzf)) return 2'd2;
        if (c == 5'd1 && ovf) return 2'd1;
        return 2'd0;
    endfunction

    function automatic int exp_port(input logic r0, input logic r1);
        if (r0 && r1) return (last_srv == 1) ? 0 : 1;
        return r0 ? 0 : 1;
    endfunction

    // One complete operation from requester p; called at a negedge in IDLE.
    task automatic run_op(input int p, input logic [4:0] c, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic ovf, input logic dbzf);
        int n;
        logic [W-1:0] ed;
        ovf_drv = ovf;
        dbz_drv = dbzf;
        if (p == 0) begin req0 = 1; cmd0 = c; a0 = a; b0 = b; end
        else        begin req1 = 1; cmd1 = c; a1 = a; b1 = b; end
        #1;
        check("op_gnt", {62'd0, gnt1, gnt0}, (exp_port(p == 0, p == 1) == 0) ? 64'd1 : 64'd2);
        last_srv = p;
        @(negedge clk);
        req0 = 0;
        req1 = 0;
        if (legal(c)) begin
            check("issue_noop", alu_noOp, 0);
            check("issue_cmd", alu_cmd, c);
            check("issue_a", alu_A, a);
            check("issue_b", alu_B, b);
        end else begin
            check("ill_noop", alu_noOp, 1);
        end
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
            if (!rsp_valid) check("wait_noop", alu_noOp, 1);
        end
        check("latency", n, legal(c) ? 2 + LAT : 1);
        ed = legal(c) ? alu_fn(c, a, b) : '0;
        check("rsp_id", rsp_id, p);
        check("rsp_data", rsp_data, ed);
        check("rsp_err", rsp_err, exp_err(c, b, ovf, dbzf));
        @(negedge clk);
        check("idle_after", busy, 0);
        ovf_drv = 0;
        dbz_drv = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int ng, nr, cyc, last_g, ep, n;
        int exp_ids[$];
        logic [W-1:0] exp_d [2];
        logic [W-1:0] held;
        logic [4:0] rc;
        logic [N-1:0] ra, rb;

        RST = 1; req0 = 1; req1 = 1; cmd0 = 5'd1; cmd1 = 5'd1;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0; rsp_ready = 1;
        ovf_drv = 0; dbz_drv = 0;

        // Reset held three cycles with both requests up.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_alu_rst", alu_rst, 1);
            check("rst_noop", alu_noOp, 1);
            check("rst_valid", rsp_valid, 0);
            check("rst_gnt", {62'd0, gnt1, gnt0}, 0);
        end
        req0 = 0; req1 = 0; RST = 0;
        #1;
        check("post_rst_alu_rst", alu_rst, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_data", rsp_data, 0);
        check("post_rst_alu_a", alu_A, 0);
        check("post_rst_alu_cmd", alu_cmd, 0);
        check("post_rst_err", rsp_err, 0);
        check("post_rst_id", rsp_id, 0);
        @(negedge clk);

        // Directed operations.
        run_op(0, 5'd1, 16'd10, 16'd20, 0, 0);          // add -> 30
        run_op(1, 5'd4, 16'd60000, 16'd0, 0, 0);        // divide by zero
        run_op(0, 5'd1, 16'hFFFF, 16'd1, 1, 0);         // add with overflow
        run_op(1, 5'd2, 16'd50, 16'd7, 1, 0);           // sub: overflow ignored
        run_op(0, 5'd4, 16'd100, 16'd7, 1, 0);          // div: overflow ignored
        run_op(1, 5'd3, 16'd300, 16'd300, 0, 1);        // mul: divByZero ignored
        run_op(0, 5'b10100, 16'd1, 16'd2, 0, 0);        // illegal
        run_op(1, 5'd0, 16'd1, 16'd2, 0, 0);            // illegal zero
        run_op(0, 5'd14, 16'd1, 16'd2, 0, 0);           // just above OP_MAX
        run_op(1, 5'd13, 16'h00F0, 16'h0F0F, 0, 0);     // highest legal opcode

        // Contention: both requesters held high for four operations.
        req0 = 1; req1 = 1; cmd0 = 5'd1; cmd1 = 5'd2;
        a0 = 16'd1000; b0 = 16'd234; a1 = 16'd900; b1 = 16'd33;
        exp_d[0] = alu_fn(5'd1, 16'd1000, 16'd234);
        exp_d[1] = alu_fn(5'd2, 16'd900, 16'd33);
        ng = 0; nr = 0; cyc = 0; last_g = 0;
        while (nr < 4 && cyc < 200) begin
            #1;
            if (gnt0 || gnt1) begin
                ep = exp_port(req0, req1);
                check("cont_gnt", {62'd0, gnt1, gnt0}, (ep == 0) ? 64'd1 : 64'd2);
                if (ng > 0) check("cont_period", cyc - last_g, 3 + LAT);
                last_srv = ep;
                last_g = cyc;
                exp_ids.push_back(ep);
                ng++;
            end
            if (rsp_valid) begin
                if (exp_ids.size() > 0) begin
                    ep = exp_ids.pop_front();
                    check("cont_id", rsp_id, ep);
                    check("cont_data", rsp_data, exp_d[ep]);
                end else begin
                    check("cont_unexpected_rsp", rsp_valid, 0);
                end
                nr++;
            end
            @(negedge clk);
            cyc++;
            if (ng >= 4) begin req0 = 0; req1 = 0; end
        end
        check("cont_rsp_count", nr, 4);
        check("cont_gnt_count", ng, 4);

        // Backpressure: response held while rsp_ready is low.
        rsp_ready = 0;
        req0 = 1; cmd0 = 5'd3; a0 = 16'd7; b0 = 16'd9;
        #1;
        check("bp_gnt", {62'd0, gnt1, gnt0}, (exp_port(1, 0) == 0) ? 64'd1 : 64'd2);
        last_srv = 0;
        @(negedge clk);
        req0 = 0;
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        check("bp_valid_seen", rsp_valid, 1);
        held = rsp_data;
        check("bp_data", held, alu_fn(5'd3, 16'd7, 16'd9));
        req1 = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_data", rsp_data, alu_fn(5'd3, 16'd7, 16'd9));
            check("bp_hold_gnt", {62'd0, gnt1, gnt0}, 0);
            check("bp_hold_busy", busy, 1);
            @(negedge clk);
        end
        req1 = 0;
        rsp_ready = 1;
        @(negedge clk);
        check("bp_release", busy, 0);

        // Reset during WAIT aborts the operation.
        req0 = 1; cmd0 = 5'd1; a0 = 16'd1; b0 = 16'd2;
        #1;
        check("rmid_gnt", {62'd0, gnt1, gnt0}, 1);
        @(negedge clk);
        req0 = 0;
        @(negedge clk);
        check("rmid_busy_wait", busy, 1);
        check("rmid_valid_wait", rsp_valid, 0);
        RST = 1; req0 = 1;
        #1;
        check("rmid_alu_rst", alu_rst, 1);
        check("rmid_gnt_rst", {62'd0, gnt1, gnt0}, 0);
        @(negedge clk);
        check("rmid_busy", busy, 0);
        check("rmid_valid", rsp_valid, 0);
        check("rmid_data", rsp_data, 0);
        req0 = 0; RST = 0;
        last_srv = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rmid_no_rsp", rsp_valid, 0);
        end

        // Randomised operations against the reference rules.
        for (int i = 0; i < 40; i++) begin
            rc = 5'($urandom_range(0, 17));
            ra = N'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            run_op(int'($urandom_range(0, 1)), rc, ra, rb,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Shares one breadboard ALU between two requesters.
- Round-robin arbitrates requests and drives the ALU operand, command, noOp and reset inputs.
- Waits a fixed ALU latency, then returns the accumulator result with an error code over a valid/ready response channel.
- Sits between the requesting blocks and the ALU; it is the only block that drives the ALU inputs.

Parameters:
- N, 16, operand width; result width is 2*N.
- ALU_LAT, 1, cycles from the issue cycle to accumulator result valid (range 1..7).
- OP_MAX, 13, highest legal opcode; legal opcodes are 1..OP_MAX.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- req0 / req1  in  1  request valid, one per requester.
- cmd0 / cmd1  in  5  requested opcode.
- a0 / a1  in  N  operand A.
- b0 / b1  in  N  operand B.
- gnt0 / gnt1  out  1  grant; combinational, high only in IDLE.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_id  out  1  requester index of the response.
- rsp_data  out  2N  accumulator result.
- rsp_err  out  2  error code: 0 ok, 1 overflow, 2 divide-by-zero, 3 illegal opcode.
- busy  out  1  high whenever the state is not IDLE.
- alu_A / alu_B  out  N  ALU operands.
- alu_cmd  out  5  ALU opcode.
- alu_noOp  out  1  ALU hold.
- alu_rst  out  1  ALU reset.
- alu_acc  in  2N  ALU accumulator output.
- alu_overflow  in  1  ALU overflow flag.
- alu_divByZero  in  1  ALU divide-by-zero flag.

Behaviour:
- Reset values (RST sampled high):
  - State IDLE; rr pointer favours port 0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0.
  - alu_A=0, alu_B=0, alu_cmd=0, alu_noOp=1.
  - alu_rst=1 for every cycle RST is high; alu_rst=0 otherwise.
- RST mid-operation aborts the operation: no response is produced for it and no grant is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Exactly one gnt is high if any req is high.
  - If both req are high, grant the port not served last.
  - A transfer occurs on the edge where req&gnt is high: latch id, cmd, a, b and toggle the rr pointer to the served port.
  - Legal cmd goes to ISSUE; illegal cmd (0 or >OP_MAX) goes to RESP with rsp_err=3, rsp_data=0, and the ALU is not touched.
- ISSUE (exactly 1 cycle):
  - Drive alu_A, alu_B, alu_cmd from the latched values with alu_noOp=0.
  - Load the wait counter with ALU_LAT-1.
- WAIT:
  - alu_noOp=1; the ALU holds its accumulator.
  - Counter decrements each cycle.
  - At 0, capture alu_acc into rsp_data, capture the error code, and go to RESP.
  - Error priority when capturing: divByZero (only if cmd=div, 5'b00100) > overflow (only if cmd=add, 5'b00001) > ok. Both flags are ignored for all other opcodes.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable.
  - When rsp_valid&rsp_ready, go to IDLE; the next grant can occur in the following cycle.
- Latency: the response is valid on cycle 2+ALU_LAT after the transfer edge (default 3).
- Throughput is one operation per 3+ALU_LAT cycles when rsp_ready is held high.
- alu_A, alu_B and alu_cmd hold their last values outside ISSUE; only alu_noOp gates the ALU.
- A req dropped before it is granted is lost. A requester must keep its inputs stable until granted.
- While rsp_ready is low, RESP holds indefinitely and both gnt stay 0.

Decomposition:
- Package alu_ctrl_pkg holds:
  - opcode constants add..nxOr (1..13);
  - error codes ERR_OK, ERR_OVF, ERR_DIV0, ERR_ILL;
  - the state encoding.
- One sub-module, rr_arb2: inputs req[1:0] and last; outputs gnt[1:0]; purely combinational. The pointer register stays in the parent.

Test Plan:
- Reset: hold RST 3 cycles → alu_rst=1 each cycle, alu_noOp=1, rsp_valid=0, gnt=00 even with both req high.
- Single add: req0 with cmd=1, a0=10, b0=20 → ISSUE shows alu_cmd=1, alu_noOp=0; response 3 cycles after the transfer edge with rsp_data=30, rsp_err=0, rsp_id=0.
- Contention: req0 and req1 held high, rsp_ready=1, four operations → grant order 0,1,0,1; rsp_id sequence 0,1,0,1.
- Divide by zero: cmd=4, a=60000, b=0, model asserts alu_divByZero → rsp_err=2. Overflow: cmd=1 with alu_overflow=1 → rsp_err=1. cmd=2 with alu_overflow=1 → rsp_err=0.
- Illegal opcode: cmd=5'b10100 → rsp_err=3 the cycle after the transfer, rsp_data=0, alu_noOp stays 1 throughout.
- Backpressure and reset mid-op: rsp_ready=0 for 5 cycles → rsp_valid and rsp_data stable, gnt=00. Then assert RST during WAIT → IDLE next cycle, no response, busy=0.
